// File: rtl/pmp_seq_checker.sv
// Sequential PMP checker: one shared address matcher walks the PMP entries
// in priority order, one entry per cycle, and resolves R/W/X permission from
// the first entry that matches.

// Single-entry address matcher (OFF, TOR and NAPOT; NA4 never matches).
module pmp_entry #(
  parameter int unsigned PLEN = 56
) (
  input  logic [PLEN-1:0] addr_i,
  input  logic [PLEN-1:0] conf_addr_i,
  input  logic [PLEN-3:0] conf_addr_prev_i,
  input  logic [1:0]      conf_addr_mode_i,
  output logic            match_o
);
  logic [PLEN+1:0] w_addr, w_top, w_base, w_dc;

  assign w_addr = {2'b00, addr_i};
  assign w_top  = {conf_addr_i, 2'b00};
  assign w_base = {2'b00, conf_addr_prev_i, 2'b00};
  // Trailing ones of pmpaddr plus the two implied byte bits are don't-care.
  assign w_dc   = {conf_addr_i ^ (conf_addr_i + PLEN'(1)), 2'b11};

  // Region compare selected by the address-matching mode.
  always_comb begin
    match_o = 1'b0;
    case (conf_addr_mode_i)
      2'b01:   match_o = (w_addr >= w_base) && (w_addr < w_top);
      2'b11:   match_o = ((w_addr ^ w_top) & ~w_dc) == '0;
      default: match_o = 1'b0;
    endcase
  end
endmodule

module pmp_seq_checker #(
  parameter int unsigned PLEN       = 56,
  parameter int unsigned PMP_LEN    = 54,
  parameter int unsigned NR_ENTRIES = 16,
  localparam int unsigned IDX_W     = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 flush_i,
  input  logic                                 req_valid_i,
  output logic                                 req_ready_o,
  input  logic [PLEN-1:0]                      addr_i,
  input  logic [1:0]                           access_i,
  input  logic [1:0]                           priv_i,
  input  logic [NR_ENTRIES-1:0][7:0]           pmpcfg_i,
  input  logic [NR_ENTRIES-1:0][PMP_LEN-1:0]   pmpaddr_i,
  output logic                                 resp_valid_o,
  input  logic                                 resp_ready_i,
  output logic                                 allow_o,
  output logic                                 matched_o,
  output logic [IDX_W-1:0]                     match_idx_o
);
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [PLEN-1:0]  r_addr;
  logic [1:0]       r_access;
  logic [1:0]       r_priv;
  logic             r_resp_valid, r_allow, r_matched;
  logic [IDX_W-1:0] r_match_idx;

  logic [7:0]       w_cfg;
  logic [PLEN-1:0]  w_conf_addr;
  logic [PLEN-3:0]  w_conf_prev;
  logic             w_match, w_perm, w_allow, w_last, w_accept;
  logic             w_unused;

  assign w_cfg    = pmpcfg_i[r_idx];
  assign w_last   = (r_idx == IDX_W'(NR_ENTRIES - 1));
  assign w_unused = ^w_cfg[6:5];

  // Zero-extend the current and previous pmpaddr for the shared matcher.
  always_comb begin
    w_conf_addr = '0;
    w_conf_prev = '0;
    w_conf_addr[PMP_LEN-1:0] = pmpaddr_i[r_idx];
    if (r_idx != '0) w_conf_prev[PMP_LEN-1:0] = pmpaddr_i[r_idx - IDX_W'(1)];
  end

  pmp_entry #(.PLEN(PLEN)) u_entry (
    .addr_i           (r_addr),
    .conf_addr_i      (w_conf_addr),
    .conf_addr_prev_i (w_conf_prev),
    .conf_addr_mode_i (w_cfg[4:3]),
    .match_o          (w_match)
  );

  // Permission of the entry under test; unlocked entries never restrict M.
  always_comb begin
    w_perm = 1'b0;
    case (r_access)
      2'd0:    w_perm = w_cfg[0];
      2'd1:    w_perm = w_cfg[1];
      2'd2:    w_perm = w_cfg[2];
      default: w_perm = 1'b0;
    endcase
    w_allow = ((r_priv == 2'b11) && !w_cfg[7]) ? 1'b1 : w_perm;
  end

  assign req_ready_o = (r_state == S_IDLE) && !flush_i && !rst_i;
  assign w_accept    = req_valid_i && req_ready_o;

  // Scan FSM with registered result outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_addr       <= '0;
      r_access     <= '0;
      r_priv       <= '0;
      r_resp_valid <= 1'b0;
      r_allow      <= 1'b0;
      r_matched    <= 1'b0;
      r_match_idx  <= '0;
    end else if (flush_i) begin
      r_state      <= S_IDLE;
      r_resp_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_addr   <= addr_i;
          r_access <= access_i;
          r_priv   <= priv_i;
          r_idx    <= '0;
          r_state  <= S_SCAN;
        end
        S_SCAN: begin
          if (w_match) begin
            r_matched    <= 1'b1;
            r_match_idx  <= r_idx;
            r_allow      <= w_allow;
            r_resp_valid <= 1'b1;
            r_state      <= S_DONE;
          end else if (w_last) begin
            r_matched    <= 1'b0;
            r_match_idx  <= '0;
            r_allow      <= (r_priv == 2'b11);
            r_resp_valid <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        S_DONE: if (resp_ready_i) begin
          r_resp_valid <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign resp_valid_o = r_resp_valid;
  assign allow_o      = r_allow;
  assign matched_o    = r_matched;
  assign match_idx_o  = r_match_idx;
endmodule

// File: doc/pmp_seq_checker.md
# pmp_seq_checker

Sequential PMP permission checker that time-shares a single `pmp_entry` matcher across all `NR_ENTRIES` PMP entries. It scans the entries in priority order, one entry per cycle, and stops at the first match. It then resolves R/W/X permission against the matched entry's config, the lock bit and the privilege level. It sits between the MMU/LSU request path and the CSR-held `pmpcfg`/`pmpaddr` state, and trades latency for area compared with a fully parallel checker.

## Interface
- `PLEN`, 56, physical address width.
- `PMP_LEN`, 54, width of each `pmpaddr` register.
- `NR_ENTRIES`, 16, number of PMP entries; range 1..64.
- `clk_i`  in  1  clock; single clock domain.
- `rst_i`  in  1  reset, synchronous, active-high.
- `flush_i`  in  1  abort any in-flight check; no response is produced.
- `req_valid_i`  in  1  check request.
- `req_ready_o`  out  1  request accepted when `req_valid_i & req_ready_o`.
- `addr_i`  in  PLEN  physical address to check.
- `access_i`  in  2  access type: 0=R, 1=W, 2=X; 3 is reserved and denied.
- `priv_i`  in  2  privilege level: 0=U, 1=S, 3=M.
- `pmpcfg_i`  in  NR_ENTRIES×8  per-entry config: [7]=L, [4:3]=A (`pmp_addr_mode_t`), [2]=X, [1]=W, [0]=R.
- `pmpaddr_i`  in  NR_ENTRIES×PMP_LEN  per-entry address registers.
- `resp_valid_o`  out  1  result valid.
- `resp_ready_i`  in  1  result consumed.
- `allow_o`  out  1  access permitted.
- `matched_o`  out  1  an entry matched.
- `match_idx_o`  out  clog2(NR_ENTRIES) (min 1)  index of the matching entry; 0 when `matched_o`=0.

## Operation
- FSM has three states: IDLE, SCAN, DONE.
- **IDLE:** `req_ready_o = ~flush_i`. On accept, register `addr_i`, `access_i` and `priv_i`, clear `idx`, and go to SCAN.
- **SCAN:** drive the single `pmp_entry` instance with:
  - `conf_addr_i = zero-extend(pmpaddr_i[idx])` to PLEN;
  - `conf_addr_prev_i = pmpaddr_i[idx-1]` (0 when idx=0), zero-extended to PLEN-2;
  - `conf_addr_mode_i = pmpcfg_i[idx][4:3]`.
- **NA4 entries:** never match (the matcher supports only OFF, TOR and NAPOT).
- **On match:**
  - Latch `matched_o=1`, `match_idx_o=idx` and `allow_o`, then go to DONE.
  - If priv=M and L=0: allow=1.
  - Otherwise: allow = the cfg bit selected by access type (R/W/X); access 3 gives 0.
- **No match:**
  - If idx=NR_ENTRIES-1, latch `matched_o=0`, `match_idx_o=0`, `allow_o=(priv==M)` and go to DONE.
  - Otherwise increment `idx`.
- **DONE:** hold `resp_valid_o=1` with stable result outputs until `resp_ready_i`, then go to IDLE.
- `pmpcfg_i`/`pmpaddr_i` are not snapshotted. The CSR side asserts `flush_i` on any PMP CSR write; a result for an unflushed scan reflects the config present in each scan cycle.
- `flush_i` in any state forces IDLE next cycle and drops any pending response.
- `rst_i` has the same effect as `flush_i` and also clears all result registers.

## Timing
- Reset values:
  - state=IDLE;
  - `resp_valid_o=0`, `allow_o=0`, `matched_o=0`, `match_idx_o=0`;
  - `req_ready_o=1` once `rst_i` is deasserted and `flush_i`=0.
- Latency, with the request accepted in cycle T:
  - entry k is evaluated in cycle T+1+k;
  - `resp_valid_o` rises in cycle T+2+k for a first match at k;
  - with no match, `resp_valid_o` rises in T+1+NR_ENTRIES.
- `req_ready_o`=0 in SCAN and DONE, so there is no pipelining.
- Minimum spacing between accepts is k+3 cycles when `resp_ready_i` is held high.
- `resp_valid_o` is registered and never drops without `resp_ready_i`, except on `flush_i` or `rst_i`.
- `flush_i` and `req_valid_i` in the same IDLE cycle: the request is not accepted.
- `flush_i` in the same cycle as the DONE handshake: the response counts as consumed; the next state is IDLE either way.
- OFF entries still consume one scan cycle each.

## Test plan
- **Reset:** assert `rst_i` for 2 cycles mid-SCAN -> all result outputs 0, `resp_valid_o`=0, `req_ready_o`=1 the cycle after deassertion; no stale response.
- **TOR hit and shadowing:**
  - Setup: entry0 TOR with pmpaddr=0x100 and cfg R=1 (covers 0x0–0x3FF); entry1 NAPOT covering the same region with cfg RW.
  - Stimulus: addr=0x200, access=W, priv=S.
  - Required: `matched_o`=1, idx=0, `allow_o`=0, `resp_valid_o` at T+2.
- **NAPOT hit at a later index:**
  - Setup: entries 0–2 OFF; entry3 NAPOT with pmpaddr=0x1FF (4 KiB at 0x0) and cfg RX.
  - X at 0xFFC, priv=U -> allow=1, idx=3, `resp_valid_o` at T+5.
  - W at the same address -> allow=0.
- **No match:** all entries OFF.
  - priv=M -> allow=1, `matched_o`=0.
  - priv=U -> allow=0.
  - Both cases: response at T+1+NR_ENTRIES.
- **Lock bit:** entry0 TOR, cfg L=1, R=0, address in range, R access.
  - priv=M -> allow=0.
  - Same entry with L=0, priv=M -> allow=1.
- **Backpressure and flush:**
  - Hold `resp_ready_i`=0 for 10 cycles -> outputs stable, `req_ready_o`=0.
  - Flush at scan index 5 -> no response, next request accepted 1 cycle after the flush.
